// File: rtl/execute_muldiv.sv
// Iterative RV M-extension execute unit: shift-add multiply and restoring divide, one bit per cycle.
// Define EXECUTE_MULDIV_DIV_EN to build the divider; without it ops 1xx complete at once with out_illegal=1.
module execute_muldiv #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_op,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]       in_rs1_value,
    input  logic [XLEN-1:0]       in_rs2_value,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  fwd_ex_we,
    input  logic [REG_ADDR_W-1:0] fwd_ex_rd,
    input  logic [XLEN-1:0]       fwd_ex_data,
    input  logic                  fwd_wb_we,
    input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0]       fwd_wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [XLEN-1:0]       out_result,
    output logic                  out_div_zero,
    output logic                  out_illegal,
    output logic                  busy
);
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              op_q, op_d;
    logic [REG_ADDR_W-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]         opa_q, opa_d;
    logic [2*XLEN-1:0]       acc_q, acc_d;
    logic                    neg_q, neg_d;
    logic                    spec_q, spec_d;
    logic                    dz_q, dz_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [XLEN-1:0]         res_q, res_d;

    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] addr,
        input logic [XLEN-1:0]       bank,
        input logic                  ex_we,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic [XLEN-1:0]       ex_data,
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic [XLEN-1:0]       wb_data
    );
        if (ex_we && (ex_rd != '0) && (ex_rd == addr)) return ex_data;
        if (wb_we && (wb_rd != '0) && (wb_rd == addr)) return wb_data;
        return bank;
    endfunction

    logic [XLEN-1:0] rs1_v, rs2_v, mag1, mag2;
    logic            sgn1, sgn2;

    assign rs1_v = fwd_sel(in_rs1_addr, in_rs1_value, fwd_ex_we, fwd_ex_rd, fwd_ex_data,
                           fwd_wb_we, fwd_wb_rd, fwd_wb_data);
    assign rs2_v = fwd_sel(in_rs2_addr, in_rs2_value, fwd_ex_we, fwd_ex_rd, fwd_ex_data,
                           fwd_wb_we, fwd_wb_rd, fwd_wb_data);
    // rs1 is signed for MULH, MULHSU, DIV, REM; rs2 for MULH, DIV, REM
    assign sgn1 = rs1_v[XLEN-1] & ((in_op == 3'b001) | (in_op == 3'b010) |
                                   (in_op == 3'b100) | (in_op == 3'b110));
    assign sgn2 = rs2_v[XLEN-1] & ((in_op == 3'b001) | (in_op == 3'b100) | (in_op == 3'b110));
    assign mag1 = sgn1 ? -rs1_v : rs1_v;
    assign mag2 = sgn2 ? -rs2_v : rs2_v;

    logic            spec_hit, spec_dz;
    logic [XLEN-1:0] spec_res;

`ifdef EXECUTE_MULDIV_DIV_EN
    localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

    always_comb begin
        spec_hit = 1'b0;
        spec_dz  = 1'b0;
        spec_res = '0;
        if (in_op[2] && (rs2_v == '0)) begin
            spec_hit = 1'b1;
            spec_dz  = 1'b1;
            spec_res = in_op[1] ? rs1_v : '1;
        end else if (in_op[2] && !in_op[0] && (rs1_v == MIN_V) && (rs2_v == '1)) begin
            spec_hit = 1'b1;
            spec_res = in_op[1] ? '0 : MIN_V;
        end
    end
`else
    assign spec_hit = in_op[2];
    assign spec_dz  = 1'b0;
    assign spec_res = '0;
`endif

    // Multiply: accumulator high half adds the multiplicand, low half holds the shifting multiplier
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_step, calc_step;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

`ifdef EXECUTE_MULDIV_DIV_EN
    // Divide: high half is the partial remainder, low half shifts the dividend out and the quotient in
    logic [XLEN:0]     div_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] div_step;

    assign div_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_ge    = div_sh >= {1'b0, opa_q};
    assign div_rem   = div_ge ? XLEN'(div_sh - {1'b0, opa_q}) : div_sh[XLEN-1:0];
    assign div_step  = {div_rem, acc_q[XLEN-2:0], div_ge};
    assign calc_step = op_q[2] ? div_step : mul_step;
`else
    assign calc_step = mul_step;
`endif

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_res;

    assign prod_fix = neg_q ? -acc_q : acc_q;

    always_comb begin
        fix_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
`ifdef EXECUTE_MULDIV_DIV_EN
        if (op_q[2]) begin
            if (op_q[1]) fix_res = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
            else         fix_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        opa_d   = opa_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        spec_d  = spec_q;
        dz_d    = dz_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    state_d = S_CALC;
                    op_d    = in_op;
                    rd_d    = in_rd;
                    cnt_d   = '0;
                    spec_d  = spec_hit;
                    dz_d    = spec_dz;
                    neg_d   = (in_op[2] && in_op[1]) ? sgn1 : (sgn1 ^ sgn2);
                    if (spec_hit) begin
                        opa_d = '0;
                        acc_d = {{XLEN{1'b0}}, spec_res};
                    end else if (in_op[2]) begin
                        opa_d = mag2;
                        acc_d = {{XLEN{1'b0}}, mag1};
                    end else begin
                        opa_d = mag1;
                        acc_d = {{XLEN{1'b0}}, mag2};
                    end
                end
            end
            S_CALC: begin
                // Special cases parked their result in the accumulator at accept
                if (spec_q) begin
                    state_d = S_DONE;
                    res_d   = acc_q[XLEN-1:0];
                end else begin
                    acc_d = calc_step;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                res_d   = fix_res;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            opa_q   <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            spec_q  <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            opa_q   <= opa_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            spec_q  <= spec_d;
            dz_q    <= dz_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    assign in_ready     = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign out_valid    = (state_q == S_DONE);
    assign out_rd       = rd_q;
    assign out_result   = res_q;
    assign out_div_zero = out_valid & dz_q;
`ifdef EXECUTE_MULDIV_DIV_EN
    assign out_illegal  = 1'b0;
`else
    assign out_illegal  = out_valid & op_q[2];
`endif

endmodule

// File: tb/tb_execute_muldiv.sv
// Bench for execute_muldiv (XLEN=32): directed vectors, forwarding, backpressure, flush, reset,
// then random operations checked against an arithmetic reference model.
module tb_execute_muldiv;
    logic        clk, rst_n, flush, in_valid, in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd;
    logic [31:0] in_rs1_value, in_rs2_value;
    logic        fwd_ex_we, fwd_wb_we;
    logic [4:0]  fwd_ex_rd, fwd_wb_rd;
    logic [31:0] fwd_ex_data, fwd_wb_data;
    logic        out_valid, out_ready, out_div_zero, out_illegal, busy;
    logic [4:0]  out_rd;
    logic [31:0] out_result;

    int checks = 0;
    int errors = 0;

    execute_muldiv #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_value(in_rs1_value), .in_rs2_value(in_rs2_value), .in_rd(in_rd),
        .fwd_ex_we(fwd_ex_we), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
        .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_result(out_result),
        .out_div_zero(out_div_zero), .out_illegal(out_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd_model(input logic [4:0] addr, input logic [31:0] bank);
        if (fwd_ex_we && fwd_ex_rd != 0 && fwd_ex_rd == addr) return fwd_ex_data;
        if (fwd_wb_we && fwd_wb_rd != 0 && fwd_wb_rd == addr) return fwd_wb_data;
        return bank;
    endfunction

    function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic dz, output logic ill,
                                      output int lat);
        logic signed [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] sa32, sb32;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa32 = a;
        sb32 = b;
        p = 0;
        r = 0;
        dz = 0;
        ill = 0;
        lat = 33;
        case (op)
            3'd0: begin p = ua * ub; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            default: begin
`ifdef EXECUTE_MULDIV_DIV_EN
                if (b == 0) begin
                    lat = 1;
                    dz = 1;
                    r = op[1] ? a : 32'hFFFF_FFFF;
                end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    lat = 1;
                    r = op[1] ? 32'h0 : 32'h8000_0000;
                end else begin
                    case (op)
                        3'd4: r = sa32 / sb32;
                        3'd5: r = a / b;
                        3'd6: r = sa32 % sb32;
                        default: r = a % b;
                    endcase
                end
`else
                lat = 1;
                ill = 1;
                r = 0;
`endif
            end
        endcase
    endfunction

    task automatic launch(input logic [2:0] op, input logic [4:0] a1, input logic [31:0] v1,
                          input logic [4:0] a2, input logic [31:0] v2, input logic [4:0] rd);
        in_op = op;
        in_rs1_addr = a1;
        in_rs1_value = v1;
        in_rs2_addr = a2;
        in_rs2_value = v2;
        in_rd = rd;
        in_valid = 1;
        @(posedge clk); #1;
        // scramble everything after accept so only latched values can matter
        in_valid = 0;
        in_op = 3'($urandom);
        in_rs1_value = $urandom;
        in_rs2_value = $urandom;
        in_rd = 5'($urandom);
        fwd_ex_data = $urandom;
        fwd_wb_data = $urandom;
    endtask

    task automatic do_op(input logic [2:0] op, input logic [4:0] a1, input logic [31:0] v1,
                         input logic [4:0] a2, input logic [31:0] v2, input logic [4:0] rd,
                         input int hold, output logic [31:0] res);
        logic [31:0] e1, e2, exp;
        logic        exp_dz, exp_ill;
        int          exp_lat, cyc;
        bit          rdy_seen;
        e1 = fwd_model(a1, v1);
        e2 = fwd_model(a2, v2);
        ref_model(op, e1, e2, exp, exp_dz, exp_ill, exp_lat);
        chk("in_ready_idle", in_ready, 1);
        launch(op, a1, v1, a2, v2, rd);
        cyc = 0;
        rdy_seen = 0;
        while (out_valid !== 1'b1 && cyc < 100) begin
            if (in_ready !== 1'b0) rdy_seen = 1;
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, exp_lat);
        chk("in_ready_busy", rdy_seen, 0);
        chk("busy_done", busy, 1);
        chk("result", out_result, exp);
        chk("out_rd", out_rd, rd);
        chk("div_zero", out_div_zero, exp_dz);
        chk("illegal", out_illegal, exp_ill);
        res = out_result;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_result", out_result, exp);
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("hs_valid", out_valid, 0);
        chk("hs_in_ready", in_ready, 1);
        chk("hs_flags", {out_div_zero, out_illegal}, 0);
    endtask

    initial begin
        logic [31:0] res;
        bit          seen;
        clk = 0;
        rst_n = 0;
        flush = 0;
        in_valid = 0;
        in_op = 0;
        in_rs1_addr = 0;
        in_rs2_addr = 0;
        in_rs1_value = 0;
        in_rs2_value = 0;
        in_rd = 0;
        fwd_ex_we = 0;
        fwd_ex_rd = 0;
        fwd_ex_data = 0;
        fwd_wb_we = 0;
        fwd_wb_rd = 0;
        fwd_wb_data = 0;
        out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_result", out_result, 0);
        chk("rst_rd", out_rd, 0);
        chk("rst_flags", {out_div_zero, out_illegal}, 0);
        rst_n = 1;
        @(posedge clk); #1;

        do_op(3'd0, 5'd1, 32'd7, 5'd2, 32'hFFFF_FFFD, 5'd3, 0, res);
        chk("vec_mul", res, 32'hFFFF_FFEB);
        do_op(3'd1, 5'd1, 32'h8000_0000, 5'd2, 32'h8000_0000, 5'd4, 0, res);
        chk("vec_mulh", res, 32'h4000_0000);
        do_op(3'd3, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, 5'd5, 0, res);
        chk("vec_mulhu", res, 32'hFFFF_FFFE);
        do_op(3'd2, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd2, 5'd6, 0, res);
        chk("vec_mulhsu", res, 32'hFFFF_FFFF);
`ifdef EXECUTE_MULDIV_DIV_EN
        do_op(3'd4, 5'd1, 32'd100, 5'd2, 32'd0, 5'd7, 0, res);
        chk("vec_div0", res, 32'hFFFF_FFFF);
        do_op(3'd7, 5'd1, 32'd100, 5'd2, 32'd0, 5'd7, 0, res);
        chk("vec_remu0", res, 32'd100);
        do_op(3'd4, 5'd1, 32'h8000_0000, 5'd2, 32'hFFFF_FFFF, 5'd8, 0, res);
        chk("vec_div_ovf", res, 32'h8000_0000);
        do_op(3'd6, 5'd1, 32'hFFFF_FFF9, 5'd2, 32'd2, 5'd8, 0, res);
        chk("vec_rem_neg", res, 32'hFFFF_FFFF);
        do_op(3'd5, 5'd1, 32'd100, 5'd2, 32'd7, 5'd8, 0, res);
        chk("vec_divu", res, 32'd14);
`else
        do_op(3'd5, 5'd1, 32'd10, 5'd2, 32'd3, 5'd7, 0, res);
        chk("vec_divu_illegal", res, 32'd0);
        do_op(3'd0, 5'd1, 32'd3, 5'd2, 32'd4, 5'd7, 0, res);
        chk("vec_mul_3x4", res, 32'd12);
`endif

        // forwarding priority and x0
        fwd_ex_we = 1; fwd_ex_rd = 5; fwd_ex_data = 3;
        fwd_wb_we = 1; fwd_wb_rd = 5; fwd_wb_data = 9;
        do_op(3'd0, 5'd5, 32'd1, 5'd6, 32'd2, 5'd9, 0, res);
        chk("fwd_ex", res, 32'd6);
        fwd_ex_we = 0; fwd_wb_data = 9;
        do_op(3'd0, 5'd5, 32'd1, 5'd6, 32'd2, 5'd9, 0, res);
        chk("fwd_wb", res, 32'd18);
        fwd_ex_we = 1; fwd_ex_rd = 0; fwd_ex_data = 3;
        fwd_wb_rd = 0; fwd_wb_data = 9;
        do_op(3'd0, 5'd0, 32'd1, 5'd6, 32'd2, 5'd9, 0, res);
        chk("fwd_x0", res, 32'd2);
        fwd_ex_we = 0;
        fwd_wb_we = 0;

        // backpressure
        do_op(3'd3, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFF, 5'd10, 5, res);

        // flush together with in_valid accepts nothing
        in_op = 3'd0;
        in_valid = 1;
        flush = 1;
        @(posedge clk); #1;
        in_valid = 0;
        flush = 0;
        chk("flush_accept_busy", busy, 0);
        chk("flush_accept_ready", in_ready, 1);
        @(posedge clk); #1;
        chk("flush_accept_valid", out_valid, 0);

        // flush in CALC cycle 10
        launch(3'd0, 5'd1, 32'd5, 5'd2, 32'd6, 5'd11);
        repeat (9) @(posedge clk);
        #1;
        chk("pre_flush_busy", busy, 1);
        flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("flush_busy", busy, 0);
        chk("flush_ready", in_ready, 1);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1;
        end
        chk("flush_no_valid", seen, 0);

        // asynchronous reset mid-CALC
        launch(3'd0, 5'd1, 32'd5, 5'd2, 32'd6, 5'd12);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_result", out_result, 0);
        chk("arst_rd", out_rd, 0);
        chk("arst_flags", {out_div_zero, out_illegal}, 0);
        #1;
        rst_n = 1;
        @(posedge clk); #1;
        chk("arst_after_busy", busy, 0);

        // random operations against the reference model
        for (int i = 0; i < 24; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom);
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 4))
                0: b = 0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = b >> 28;
                default: ;
            endcase
            fwd_ex_we = 1'($urandom);
            fwd_ex_rd = 5'($urandom_range(0, 3));
            fwd_ex_data = $urandom;
            fwd_wb_we = 1'($urandom);
            fwd_wb_rd = 5'($urandom_range(0, 3));
            fwd_wb_data = $urandom;
            do_op(op, 5'($urandom_range(0, 3)), a, 5'($urandom_range(0, 3)), b,
                  5'($urandom), $urandom_range(0, 2), res);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
